// File: rtl/screen_region_flasher_pkg.sv
// Shared defaults, FSM encoding and pixel-address helper for the framebuffer-to-VGA streamer.
package screen_region_flasher_pkg;

  localparam int SCR_WIDTH_DEF    = 160;
  localparam int SCR_HEIGHT_DEF   = 120;
  localparam int COLOR_SIZE_DEF   = 3;
  localparam int MEMORY_SIZE_BITS = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [31:0] coord_to_offset(input logic [31:0] x,
                                                  input logic [31:0] y,
                                                  input logic [31:0] width);
    return y * width + x;
  endfunction

endpackage

// File: rtl/screen_region_flasher_raster_window_counter.sv
// Clipped raster stepper: load latches a window, step walks it x-major; last_o flags the final pixel.
// empty_o is combinational from the window inputs so the start edge can skip straight to draining.
module raster_window_counter
  import screen_region_flasher_pkg::*;
#(
  parameter int SCR_WIDTH  = SCR_WIDTH_DEF,
  parameter int SCR_HEIGHT = SCR_HEIGHT_DEF,
  parameter int X_BITS     = 8,
  parameter int Y_BITS     = 7
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [X_BITS-1:0] win_x0_i,
  input  logic [X_BITS-1:0] win_w_i,
  input  logic [Y_BITS-1:0] win_y0_i,
  input  logic [Y_BITS-1:0] win_h_i,
  output logic [X_BITS-1:0] x_o,
  output logic [Y_BITS-1:0] y_o,
  output logic              last_o,
  output logic              empty_o
);

  localparam logic [X_BITS:0] X_LIM = (X_BITS+1)'(SCR_WIDTH);
  localparam logic [Y_BITS:0] Y_LIM = (Y_BITS+1)'(SCR_HEIGHT);

  logic [X_BITS:0]   x_sum, x_end;
  logic [Y_BITS:0]   y_sum, y_end;
  logic [X_BITS-1:0] x_q, x0_q, x_last_q;
  logic [Y_BITS-1:0] y_q, y_last_q;

  // One extra bit so origin+size never wraps before clipping.
  assign x_sum = {1'b0, win_x0_i} + {1'b0, win_w_i};
  assign y_sum = {1'b0, win_y0_i} + {1'b0, win_h_i};
  assign x_end = (x_sum > X_LIM) ? X_LIM : x_sum;
  assign y_end = (y_sum > Y_LIM) ? Y_LIM : y_sum;

  assign empty_o = (win_w_i == '0) || (win_h_i == '0) ||
                   ({1'b0, win_x0_i} >= X_LIM) || ({1'b0, win_y0_i} >= Y_LIM);
  assign last_o  = (x_q == x_last_q) && (y_q == y_last_q);
  assign x_o     = x_q;
  assign y_o     = y_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      x_q      <= '0;
      x0_q     <= '0;
      x_last_q <= '0;
      y_q      <= '0;
      y_last_q <= '0;
    end else if (load_i) begin
      x_q      <= win_x0_i;
      x0_q     <= win_x0_i;
      y_q      <= win_y0_i;
      x_last_q <= X_BITS'(x_end - (X_BITS+1)'(1));
      y_last_q <= Y_BITS'(y_end - (Y_BITS+1)'(1));
    end else if (step_i) begin
      if (x_q == x_last_q) begin
        x_q <= x0_q;
        y_q <= y_q + Y_BITS'(1);
      end else begin
        x_q <= x_q + X_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/screen_region_flasher.sv
// Streams a clipped framebuffer window to vga_adapter, one pixel per clock; pixel plotted READ_LATENCY+1
// cycles after its address. Completion is held on out_cont_signal until next_fin_signal consumes it.
module screen_region_flasher
  import screen_region_flasher_pkg::*;
#(
  parameter int SCR_WIDTH    = SCR_WIDTH_DEF,
  parameter int SCR_HEIGHT   = SCR_HEIGHT_DEF,
  parameter int X_BITS       = 8,
  parameter int Y_BITS       = 7,
  parameter int COLOR_SIZE   = COLOR_SIZE_DEF,
  parameter int ADDR_BITS    = MEMORY_SIZE_BITS,
  parameter int READ_LATENCY = 1
) (
  input  logic                  Clck,
  input  logic                  Reset,
  input  logic                  in_cont_signal,
  input  logic                  next_fin_signal,
  input  logic [X_BITS-1:0]     win_x0,
  input  logic [Y_BITS-1:0]     win_y0,
  input  logic [X_BITS-1:0]     win_w,
  input  logic [Y_BITS-1:0]     win_h,
  input  logic                  key_en,
  input  logic [COLOR_SIZE-1:0] key_colour,
  output logic [ADDR_BITS-1:0]  read_addr,
  input  logic [COLOR_SIZE-1:0] read_data,
  output logic [X_BITS-1:0]     x_co,
  output logic [Y_BITS-1:0]     y_co,
  output logic [COLOR_SIZE-1:0] colour,
  output logic                  plot,
  output logic                  busy,
  output logic                  out_cont_signal
);

  localparam int             RL         = READ_LATENCY;
  localparam logic [2:0]     DRAIN_LAST = 3'(RL + 1);

  state_e                state_q;
  logic [2:0]            drain_q;
  logic                  key_en_q;
  logic [COLOR_SIZE-1:0] key_col_q;
  logic [ADDR_BITS-1:0]  read_addr_q;
  logic [X_BITS-1:0]     x_co_q;
  logic [Y_BITS-1:0]     y_co_q;
  logic [COLOR_SIZE-1:0] colour_q;
  logic                  plot_q, busy_q, out_cont_q;

  // Stage 0 travels with read_addr_q; stage RL lines up with read_data.
  logic                  pipe_vld_q [0:RL];
  logic [X_BITS-1:0]     pipe_x_q   [0:RL];
  logic [Y_BITS-1:0]     pipe_y_q   [0:RL];

  logic [X_BITS-1:0]     cnt_x;
  logic [Y_BITS-1:0]     cnt_y;
  logic                  cnt_last, cnt_empty, cnt_load, cnt_step, key_hit;

  assign cnt_load = (state_q == ST_IDLE) && in_cont_signal;
  assign cnt_step = (state_q == ST_SCAN);
  assign key_hit  = key_en_q && (read_data == key_col_q);

  raster_window_counter #(
    .SCR_WIDTH (SCR_WIDTH),
    .SCR_HEIGHT(SCR_HEIGHT),
    .X_BITS    (X_BITS),
    .Y_BITS    (Y_BITS)
  ) u_cnt (
    .clk_i   (Clck),
    .rst_ni  (Reset),
    .load_i  (cnt_load),
    .step_i  (cnt_step),
    .win_x0_i(win_x0),
    .win_w_i (win_w),
    .win_y0_i(win_y0),
    .win_h_i (win_h),
    .x_o     (cnt_x),
    .y_o     (cnt_y),
    .last_o  (cnt_last),
    .empty_o (cnt_empty)
  );

  always_ff @(posedge Clck) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      drain_q     <= '0;
      key_en_q    <= 1'b0;
      key_col_q   <= '0;
      read_addr_q <= '0;
      x_co_q      <= '0;
      y_co_q      <= '0;
      colour_q    <= '0;
      plot_q      <= 1'b0;
      busy_q      <= 1'b0;
      out_cont_q  <= 1'b0;
      for (int i = 0; i <= RL; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_x_q[i]   <= '0;
        pipe_y_q[i]   <= '0;
      end
    end else begin
      pipe_vld_q[0] <= (state_q == ST_SCAN);
      pipe_x_q[0]   <= cnt_x;
      pipe_y_q[0]   <= cnt_y;
      for (int i = 1; i <= RL; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_x_q[i]   <= pipe_x_q[i-1];
        pipe_y_q[i]   <= pipe_y_q[i-1];
      end

      plot_q <= pipe_vld_q[RL] && !key_hit;
      if (pipe_vld_q[RL]) begin
        x_co_q   <= pipe_x_q[RL];
        y_co_q   <= pipe_y_q[RL];
        colour_q <= read_data;
      end

      case (state_q)
        ST_IDLE: begin
          if (in_cont_signal) begin
            key_en_q  <= key_en;
            key_col_q <= key_colour;
            busy_q    <= 1'b1;
            drain_q   <= '0;
            state_q   <= cnt_empty ? ST_DRAIN : ST_SCAN;
          end
        end
        ST_SCAN: begin
          read_addr_q <= ADDR_BITS'(coord_to_offset(32'(cnt_x), 32'(cnt_y), 32'(SCR_WIDTH)));
          if (cnt_last) begin
            state_q <= ST_DRAIN;
            drain_q <= '0;
          end
        end
        ST_DRAIN: begin
          // Counts through the final address register stage plus the read pipeline.
          if (drain_q == DRAIN_LAST) begin
            state_q    <= ST_DONE;
            busy_q     <= 1'b0;
            out_cont_q <= 1'b1;
          end else begin
            drain_q <= drain_q + 3'd1;
          end
        end
        ST_DONE: begin
          if (next_fin_signal) begin
            out_cont_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign read_addr       = read_addr_q;
  assign x_co            = x_co_q;
  assign y_co            = y_co_q;
  assign colour          = colour_q;
  assign plot            = plot_q;
  assign busy            = busy_q;
  assign out_cont_signal = out_cont_q;

endmodule

// File: tb/tb_screen_region_flasher.sv
// Scoreboard bench: expected plots (coords, colour, cycle) are queued at frame start and popped per plot.
module tb_screen_region_flasher;

  localparam int W = 160;
  localparam int H = 120;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int failed   = 0;

  logic       Reset;
  logic [7:0] win_x0, win_w;
  logic [6:0] win_y0, win_h;
  logic       key_en;
  logic [2:0] key_colour;
  logic       in_cont1, next_fin1, in_cont3, next_fin3;
  logic [14:0] addr1, addr3;
  logic [2:0] rd1, rd3, r3a, r3b;
  logic [7:0] x1, x3;
  logic [6:0] y1, y3;
  logic [2:0] col1, col3;
  logic       plot1, plot3, busy1, busy3, oc1, oc3;

  logic [2:0] mem [0:32767];
  exp_t q1[$];
  exp_t q3[$];

  // Framebuffer models: one-cycle and three-cycle read latency.
  always @(posedge clk) begin
    rd1 <= mem[addr1];
    r3a <= mem[addr3];
    r3b <= r3a;
    rd3 <= r3b;
  end

  screen_region_flasher #(.READ_LATENCY(1)) dut1 (
    .Clck(clk), .Reset(Reset), .in_cont_signal(in_cont1), .next_fin_signal(next_fin1),
    .win_x0(win_x0), .win_y0(win_y0), .win_w(win_w), .win_h(win_h),
    .key_en(key_en), .key_colour(key_colour), .read_addr(addr1), .read_data(rd1),
    .x_co(x1), .y_co(y1), .colour(col1), .plot(plot1), .busy(busy1), .out_cont_signal(oc1));

  screen_region_flasher #(.READ_LATENCY(3)) dut3 (
    .Clck(clk), .Reset(Reset), .in_cont_signal(in_cont3), .next_fin_signal(next_fin3),
    .win_x0(win_x0), .win_y0(win_y0), .win_w(win_w), .win_h(win_h),
    .key_en(key_en), .key_colour(key_colour), .read_addr(addr3), .read_data(rd3),
    .x_co(x3), .y_co(y3), .colour(col3), .plot(plot3), .busy(busy3), .out_cont_signal(oc3));

  // Pixel k of the window is expected s+k+rl+2 cycles after the start edge; keyed pixels keep their slot.
  task automatic push_window(input int x0, input int y0, input int w, input int h,
                             input int s, input int rl, input bit use3, output int n);
    int xe, ye, a;
    exp_t e;
    xe = (x0 + w > W) ? W : x0 + w;
    ye = (y0 + h > H) ? H : y0 + h;
    n = 0;
    for (int y = y0; y < ye; y++) begin
      for (int x = x0; x < xe; x++) begin
        a = y * W + x;
        if (!(key_en && mem[a] === key_colour)) begin
          e.x = 8'(x); e.y = 7'(y); e.c = mem[a]; e.cyc = s + n + rl + 2;
          if (use3) q3.push_back(e); else q1.push_back(e);
        end
        n++;
      end
    end
  endtask

  task automatic set_window(input int x0, input int y0, input int w, input int h,
                            input bit ke, input logic [2:0] kc);
    win_x0 = 8'(x0); win_y0 = 7'(y0); win_w = 8'(w); win_h = 7'(h);
    key_en = ke; key_colour = kc;
  endtask

  task automatic start1(output int s);
    @(negedge clk); in_cont1 = 1'b1;
    @(negedge clk); s = cyc; in_cont1 = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    in_cont1 = 1'b0; next_fin1 = 1'b0; in_cont3 = 1'b0; next_fin3 = 1'b0;
    set_window(0, 0, 0, 0, 1'b0, 3'd0);
    repeat (3) @(negedge clk);
    compared++;
    if ({addr1, x1, y1, col1, plot1, busy1, oc1} !== '0) begin
      failed++; $display("FAIL reset_dut1: got %h required 0", {addr1, x1, y1, col1, plot1, busy1, oc1});
    end
    compared++;
    if ({addr3, x3, y3, col3, plot3, busy3, oc3} !== '0) begin
      failed++; $display("FAIL reset_dut3: got %h required 0", {addr3, x3, y3, col3, plot3, busy3, oc3});
    end
    Reset = 1'b1;
  endtask

  task automatic test_full_screen();
    int s, n, lat;
    exp_t e;
    set_window(0, 0, W, H, 1'b0, 3'd0);
    start1(s);
    push_window(0, 0, W, H, s, 1, 1'b0, n);
    lat = -1;
    for (int c = 0; c < n + 50 && lat < 0; c++) begin
      @(negedge clk);
      if (plot1) begin
        compared++;
        if (q1.size() == 0) begin
          failed++; $display("FAIL full_plot: got plot (%0d,%0d) at cyc %0d, required none", x1, y1, cyc);
        end else begin
          e = q1.pop_front();
          if ({x1, y1, col1, cyc} !== {e.x, e.y, e.c, e.cyc}) begin
            failed++;
            $display("FAIL full_plot: got x=%0d y=%0d c=%0d cyc=%0d, required x=%0d y=%0d c=%0d cyc=%0d",
                     x1, y1, col1, cyc, e.x, e.y, e.c, e.cyc);
          end
        end
      end
      if (oc1) lat = cyc - s;
    end
    compared++;
    if (lat !== n + 3) begin failed++; $display("FAIL full_latency: got %0d required %0d", lat, n + 3); end
    compared++;
    if (q1.size() !== 0) begin failed++; $display("FAIL full_missing: got %0d left required 0", q1.size()); end
    q1.delete();
    next_fin1 = 1'b1;
    @(negedge clk); next_fin1 = 1'b0;
    compared++;
    if ({oc1, busy1} !== 2'b00) begin failed++; $display("FAIL full_handshake: got %b required 00", {oc1, busy1}); end
  endtask

  task automatic test_clip();
    int s, n, lat, plots;
    exp_t e;
    set_window(150, 115, 20, 10, 1'b0, 3'd0);
    start1(s);
    push_window(150, 115, 20, 10, s, 1, 1'b0, n);
    // Scrambling the window and key inputs mid-frame must have no effect.
    set_window($urandom_range(0, 100), $urandom_range(0, 100), $urandom_range(1, 50), $urandom_range(1, 20),
               1'b1, 3'(rd1));
    lat = -1; plots = 0;
    for (int c = 0; c < 200 && lat < 0; c++) begin
      @(negedge clk);
      if (plot1) begin
        plots++; compared++;
        if (q1.size() == 0) begin
          failed++; $display("FAIL clip_plot: got plot (%0d,%0d) at cyc %0d, required none", x1, y1, cyc);
        end else begin
          e = q1.pop_front();
          if ({x1, y1, col1, cyc} !== {e.x, e.y, e.c, e.cyc}) begin
            failed++;
            $display("FAIL clip_plot: got x=%0d y=%0d c=%0d cyc=%0d, required x=%0d y=%0d c=%0d cyc=%0d",
                     x1, y1, col1, cyc, e.x, e.y, e.c, e.cyc);
          end
        end
      end
      if (oc1) lat = cyc - s;
    end
    compared++;
    if (plots !== 50) begin failed++; $display("FAIL clip_count: got %0d required 50", plots); end
    compared++;
    if (lat !== 53) begin failed++; $display("FAIL clip_latency: got %0d required 53", lat); end
    q1.delete();
    next_fin1 = 1'b1;
    @(negedge clk); next_fin1 = 1'b0;
  endtask

  task automatic test_key();
    int s, n, lat, plots;
    exp_t e;
    mem[2*W+10] = 3'd0; mem[2*W+11] = 3'd5; mem[2*W+12] = 3'd0; mem[2*W+13] = 3'd7;
    set_window(10, 2, 4, 1, 1'b1, 3'd0);
    start1(s);
    push_window(10, 2, 4, 1, s, 1, 1'b0, n);
    lat = -1; plots = 0;
    for (int c = 0; c < 30 && lat < 0; c++) begin
      @(negedge clk);
      if (plot1) begin
        plots++; compared++;
        if (q1.size() == 0) begin
          failed++; $display("FAIL key_plot: got plot (%0d,%0d) at cyc %0d, required none", x1, y1, cyc);
        end else begin
          e = q1.pop_front();
          if ({x1, y1, col1, cyc} !== {e.x, e.y, e.c, e.cyc}) begin
            failed++;
            $display("FAIL key_plot: got x=%0d y=%0d c=%0d cyc=%0d, required x=%0d y=%0d c=%0d cyc=%0d",
                     x1, y1, col1, cyc, e.x, e.y, e.c, e.cyc);
          end
        end
      end
      if (oc1) lat = cyc - s;
    end
    compared++;
    if (plots !== 2) begin failed++; $display("FAIL key_count: got %0d required 2", plots); end
    compared++;
    if (lat !== 7) begin failed++; $display("FAIL key_latency: got %0d required 7", lat); end
    q1.delete();
    next_fin1 = 1'b1;
    @(negedge clk); next_fin1 = 1'b0;
    key_en = 1'b0;
  endtask

  task automatic test_latency3();
    int s, n, lat, plots;
    exp_t e;
    set_window(5, 5, 2, 2, 1'b0, 3'd0);
    @(negedge clk); in_cont3 = 1'b1;
    @(negedge clk); s = cyc; in_cont3 = 1'b0;
    push_window(5, 5, 2, 2, s, 3, 1'b1, n);
    lat = -1; plots = 0;
    for (int c = 0; c < 30 && lat < 0; c++) begin
      @(negedge clk);
      if (plot3) begin
        plots++; compared++;
        if (q3.size() == 0) begin
          failed++; $display("FAIL rl3_plot: got plot (%0d,%0d) at cyc %0d, required none", x3, y3, cyc);
        end else begin
          e = q3.pop_front();
          if ({x3, y3, col3, cyc} !== {e.x, e.y, e.c, e.cyc}) begin
            failed++;
            $display("FAIL rl3_plot: got x=%0d y=%0d c=%0d cyc=%0d, required x=%0d y=%0d c=%0d cyc=%0d",
                     x3, y3, col3, cyc, e.x, e.y, e.c, e.cyc);
          end
        end
      end
      if (oc3) lat = cyc - s;
    end
    compared++;
    if (plots !== 4) begin failed++; $display("FAIL rl3_count: got %0d required 4", plots); end
    compared++;
    if (lat !== 9) begin failed++; $display("FAIL rl3_latency: got %0d required 9", lat); end
    q3.delete();
    next_fin3 = 1'b1;
    @(negedge clk); next_fin3 = 1'b0;
    compared++;
    if (oc3 !== 1'b0) begin failed++; $display("FAIL rl3_handshake: got %b required 0", oc3); end
  endtask

  task automatic test_reset_mid();
    int s, n, lat;
    exp_t e;
    set_window(0, 0, W, H, 1'b0, 3'd0);
    for (int pass = 0; pass < 2; pass++) begin
      start1(s);
      push_window(0, 0, W, H, s, 1, 1'b0, n);
      lat = -1;
      for (int c = 0; c < ((pass == 0) ? 40 : n + 50) && lat < 0; c++) begin
        @(negedge clk);
        if (plot1) begin
          compared++;
          if (q1.size() == 0) begin
            failed++; $display("FAIL rst_plot: got plot (%0d,%0d) at cyc %0d, required none", x1, y1, cyc);
          end else begin
            e = q1.pop_front();
            if ({x1, y1, col1, cyc} !== {e.x, e.y, e.c, e.cyc}) begin
              failed++;
              $display("FAIL rst_plot: got x=%0d y=%0d c=%0d cyc=%0d, required x=%0d y=%0d c=%0d cyc=%0d",
                       x1, y1, col1, cyc, e.x, e.y, e.c, e.cyc);
            end
          end
        end
        if (oc1) lat = cyc - s;
      end
      if (pass == 0) begin
        compared++;
        if (busy1 !== 1'b1) begin failed++; $display("FAIL rst_busy_before: got %b required 1", busy1); end
        Reset = 1'b0;
        q1.delete();
        @(negedge clk);
        compared++;
        if ({addr1, x1, y1, col1, plot1, busy1, oc1} !== '0) begin
          failed++; $display("FAIL rst_mid_outputs: got %h required 0", {addr1, x1, y1, col1, plot1, busy1, oc1});
        end
        repeat (2) @(negedge clk);
        Reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          compared++;
          if ({plot1, busy1} !== 2'b00) begin
            failed++; $display("FAIL rst_quiet: got plot/busy %b required 00", {plot1, busy1});
          end
        end
      end else begin
        compared++;
        if (lat !== n + 3) begin failed++; $display("FAIL rst_restart_latency: got %0d required %0d", lat, n + 3); end
        compared++;
        if (q1.size() !== 0) begin failed++; $display("FAIL rst_restart_missing: got %0d required 0", q1.size()); end
        q1.delete();
        next_fin1 = 1'b1;
        @(negedge clk); next_fin1 = 1'b0;
      end
    end
  endtask

  task automatic test_empty_chain();
    int s, n, lat;
    exp_t e;
    set_window(20, 20, 0, 5, 1'b0, 3'd0);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        start1(s);
        n = 0;
      end else begin
        set_window(0, 0, 3, 1, 1'b0, 3'd0);
        next_fin1 = 1'b1; in_cont1 = 1'b1;
        @(negedge clk);
        compared++;
        if ({oc1, busy1} !== 2'b00) begin failed++; $display("FAIL chain_release: got %b required 00", {oc1, busy1}); end
        next_fin1 = 1'b0;
        @(negedge clk); s = cyc; in_cont1 = 1'b0;
        compared++;
        if (busy1 !== 1'b1) begin failed++; $display("FAIL chain_start: got busy %b required 1", busy1); end
        push_window(0, 0, 3, 1, s, 1, 1'b0, n);
      end
      lat = -1;
      for (int c = 0; c < 20 && lat < 0; c++) begin
        @(negedge clk);
        if (plot1) begin
          compared++;
          if (q1.size() == 0) begin
            failed++; $display("FAIL empty_plot: got plot (%0d,%0d) at cyc %0d, required none", x1, y1, cyc);
          end else begin
            e = q1.pop_front();
            if ({x1, y1, col1, cyc} !== {e.x, e.y, e.c, e.cyc}) begin
              failed++;
              $display("FAIL empty_plot: got x=%0d y=%0d c=%0d cyc=%0d, required x=%0d y=%0d c=%0d cyc=%0d",
                       x1, y1, col1, cyc, e.x, e.y, e.c, e.cyc);
            end
          end
        end
        if (oc1) lat = cyc - s;
      end
      compared++;
      if (lat !== n + 3) begin failed++; $display("FAIL empty_latency: got %0d required %0d", lat, n + 3); end
      if (pass == 0) begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          compared++;
          if (oc1 !== 1'b1) begin failed++; $display("FAIL done_hold: got %b required 1", oc1); end
        end
      end
    end
    compared++;
    if (q1.size() !== 0) begin failed++; $display("FAIL chain_missing: got %0d required 0", q1.size()); end
    q1.delete();
    next_fin1 = 1'b1;
    @(negedge clk); next_fin1 = 1'b0;
  endtask

  initial begin
    Reset = 1'b0;
    in_cont1 = 1'b0; next_fin1 = 1'b0; in_cont3 = 1'b0; next_fin3 = 1'b0;
    for (int a = 0; a < 32768; a++) mem[a] = 3'(a);
    test_reset();
    test_full_screen();
    test_clip();
    test_key();
    test_latency3();
    test_reset_mid();
    test_empty_chain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
